// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM state
// encodings, the default halt encoding and the delivered-count width.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;
  localparam int          CNT_W         = 16;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection: jump beats branch, branch beats sequential increment.
// The increment wraps naturally at 2^ADDR_W.
module pc_next_mux #(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_target_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic [ADDR_W-1:0] next_pc_o
);

  // Priority redirect mux
  always_comb begin
    if (jump_i)              next_pc_o = jump_target_i;
    else if (branch_taken_i) next_pc_o = branch_target_i;
    else                     next_pc_o = pc_i + ADDR_W'(1);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer. Drives the PC to instruction memory, registers
// the returned word one cycle later, and stops on the halt encoding.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int                ADDR_W    = 5,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(HALT_WORD_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [DATA_W-1:0] instru,
  output logic [ADDR_W-1:0] direinstru,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_nxt;
  logic [DATA_W-1:0] out_q, out_d;
  logic              vld_q, vld_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  pc_next_mux #(.ADDR_W(ADDR_W)) u_pc_next_mux (
    .pc_i            (pc_q),
    .jump_i          (jump),
    .jump_target_i   (jump_target),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .next_pc_o       (pc_nxt)
  );

  // Next-state logic; everything holds unless a fetch completes or start fires.
  // instr_valid defaults low so it pulses for exactly one cycle per delivery.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    out_d   = out_q;
    vld_d   = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = ST_RUN;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        // Redirects are only honoured on a cycle that actually fetches.
        if (!stall) begin
          if (instru == HALT_WORD) begin
            state_d = ST_HALT;
          end else begin
            out_d = instru;
            vld_d = 1'b1;
            pc_d  = pc_nxt;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

  assign direinstru  = pc_q;
  assign instr_out   = out_q;
  assign instr_valid = vld_q;
  assign halted      = (state_q == ST_HALT);
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a directed vector table, hand-written corner
// sequences, then randomized traffic against a behavioural model.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  localparam int          AW   = 5;
  localparam int          DW   = 32;
  localparam logic [31:0] HALT = HALT_WORD_DEF;

  logic          clk = 1'b0;
  logic          reset, start, stall, jump, branch_taken;
  logic [AW-1:0] jump_target, branch_target, direinstru;
  logic [DW-1:0] instru, instr_out;
  logic          instr_valid, halted;
  logic [15:0]   fetch_count;

  logic [DW-1:0] mem [32];
  assign instru = mem[direinstru];

  always #5 clk = ~clk;

  fetch_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .jump(jump), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .instru(instru), .direinstru(direinstru), .instr_out(instr_out),
    .instr_valid(instr_valid), .halted(halted), .fetch_count(fetch_count)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int pc, input logic vld,
                         input logic [31:0] out, input logic hlt, input int cnt);
    chk({tag, ".pc"},    32'(direinstru),  32'(pc));
    chk({tag, ".vld"},   32'(instr_valid), 32'(vld));
    chk({tag, ".out"},   instr_out,        out);
    chk({tag, ".halt"},  32'(halted),      32'(hlt));
    chk({tag, ".cnt"},   32'(fetch_count), 32'(cnt));
  endtask

  task automatic drive(input logic r, input logic s, input logic st,
                       input logic j, input int jt, input logic b, input int bt);
    reset = r; start = s; stall = st; jump = j; branch_taken = b;
    jump_target = AW'(jt); branch_target = AW'(bt);
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- behavioural reference model ----------------
  int          m_mode;   // 0 idle, 1 running, 2 halted
  int          m_pc, m_cnt;
  logic [31:0] m_out;
  logic        m_vld;

  task automatic model_edge();
    logic [31:0] w;
    w = mem[m_pc];
    m_vld = 1'b0;
    if (reset) begin
      m_mode = 0; m_pc = 0; m_cnt = 0; m_out = '0;
    end else if (m_mode != 1) begin
      if (start) begin m_mode = 1; m_pc = 0; m_cnt = 0; end
    end else if (!stall) begin
      if (w == HALT) m_mode = 2;
      else begin
        m_out = w; m_vld = 1'b1;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        if (jump)              m_pc = int'(jump_target);
        else if (branch_taken) m_pc = int'(branch_target);
        else                   m_pc = (m_pc + 1) % 32;
      end
    end
  endtask

  // One clock: model follows the same pre-edge inputs; outputs checked at negedge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic run_n(input int n);
    idle_in();
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic r, s, st, j; int jt; logic b; int bt;
    int pc; logic vld; logic [31:0] out; logic hlt; int cnt;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(logic r, logic s, logic st, logic j, int jt, logic b, int bt,
                              int pc, logic vld, logic [31:0] out, logic hlt, int cnt);
    vec_t v;
    v.r = r; v.s = s; v.st = st; v.j = j; v.jt = jt; v.b = b; v.bt = bt;
    v.pc = pc; v.vld = vld; v.out = out; v.hlt = hlt; v.cnt = cnt;
    return v;
  endfunction

  initial begin
    idle_in();
    reset = 1'b1;
    m_mode = 0; m_pc = 0; m_cnt = 0; m_out = '0; m_vld = 1'b0;

    // Memory: word = address, halt word at address 6
    for (int i = 0; i < 32; i++) mem[i] = 32'(i);
    mem[6] = HALT;

    //           r s st j jt b bt    pc vld out hlt cnt
    tbl[0]  = mk(1,0,0, 0,0, 0,0,    0, 0, 0, 0, 0);
    tbl[1]  = mk(0,1,0, 0,0, 0,0,    0, 0, 0, 0, 0);
    tbl[2]  = mk(0,0,0, 0,0, 0,0,    1, 1, 0, 0, 1);
    tbl[3]  = mk(0,0,0, 0,0, 0,0,    2, 1, 1, 0, 2);
    tbl[4]  = mk(0,1,0, 0,0, 0,0,    3, 1, 2, 0, 3);   // start ignored in RUN
    tbl[5]  = mk(0,0,0, 0,0, 0,0,    4, 1, 3, 0, 4);
    tbl[6]  = mk(0,0,0, 0,0, 0,0,    5, 1, 4, 0, 5);
    tbl[7]  = mk(0,0,0, 0,0, 0,0,    6, 1, 5, 0, 6);
    tbl[8]  = mk(0,0,0, 1,20,1,10,   6, 0, 5, 1, 6);   // halt word: redirect ignored
    tbl[9]  = mk(0,0,1, 1,20,1,10,   6, 0, 5, 1, 6);   // HALT ignores everything
    tbl[10] = mk(0,1,0, 0,0, 0,0,    0, 0, 5, 0, 0);   // restart from HALT
    tbl[11] = mk(0,0,0, 0,0, 0,0,    1, 1, 0, 0, 1);
    tbl[12] = mk(1,1,0, 0,0, 0,0,    0, 0, 0, 0, 0);   // reset beats start
    tbl[13] = mk(0,0,0, 0,0, 0,0,    0, 0, 0, 0, 0);   // still idle after reset

    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].st, tbl[i].j, tbl[i].jt, tbl[i].b, tbl[i].bt);
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].pc, tbl[i].vld, tbl[i].out, tbl[i].hlt, tbl[i].cnt);
    end

    // ---------------- hand-written sequences ----------------
    // No halt word anywhere; distinct payloads
    for (int i = 0; i < 32; i++) mem[i] = 32'h100 + 32'(i);

    // Redirect priority
    drive(1, 0, 0, 0, 0, 0, 0); step();
    drive(0, 1, 0, 0, 0, 0, 0); step();
    run_n(3);
    chk_all("pre_redir", 3, 1, 32'h102, 0, 3);
    drive(0, 0, 0, 1, 20, 1, 10); step();
    chk_all("jump_over_branch", 20, 1, 32'h103, 0, 4);
    drive(0, 0, 0, 1, 4, 0, 0); step();
    chk("to_pc4", 32'(direinstru), 32'd4);
    drive(0, 0, 0, 0, 0, 1, 10); step();
    chk_all("branch_only", 10, 1, 32'h104, 0, 6);

    // Stall at PC=7 with jump asserted
    drive(0, 0, 0, 1, 7, 0, 0); step();
    chk("to_pc7", 32'(direinstru), 32'd7);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1, 20, 1, 10); step();
      chk_all($sformatf("stall%0d", i), 7, 0, 32'h10A, 0, 7);
    end
    idle_in(); step();
    chk_all("stall_release", 8, 1, 32'h107, 0, 8);

    // Reset mid-run at PC=12, count=12
    drive(1, 0, 0, 0, 0, 0, 0); step();
    drive(0, 1, 0, 0, 0, 0, 0); step();
    run_n(12);
    chk_all("pre_reset", 12, 1, 32'h10B, 0, 12);
    drive(1, 0, 0, 0, 0, 0, 0); step();
    chk_all("mid_reset", 0, 0, 0, 0, 0);
    idle_in(); step();
    chk_all("post_reset_idle", 0, 0, 0, 0, 0);

    // Wrap-around: 33 fetches
    drive(0, 1, 0, 0, 0, 0, 0); step();
    run_n(31);
    chk("wrap_pc31", 32'(direinstru), 32'd31);
    run_n(1);
    chk_all("wrap_pc0", 0, 1, 32'h11F, 0, 32);
    run_n(1);
    chk_all("wrap_33", 1, 1, 32'h100, 0, 33);

    // ---------------- randomized traffic vs model ----------------
    drive(1, 0, 0, 0, 0, 0, 0); step();
    for (int blk = 0; blk < 10; blk++) begin
      for (int i = 0; i < 32; i++)
        mem[i] = ($urandom_range(0, 11) == 0) ? HALT : $urandom;
      for (int c = 0; c < 200; c++) begin
        drive($urandom_range(0, 79) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
              int'($urandom_range(0, 31)), $urandom_range(0, 5) == 0,
              int'($urandom_range(0, 31)));
        step();
        chk_all("rand", m_pc, m_vld, m_out, m_mode == 2, m_cnt);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
